// File: rtl/rgb_pkg.sv
// Shared types for the RGB hue fader: hue sector encoding and the
// sector-to-duty mapping used by rgb_hue_fader.
package rgb_pkg;

    // Hue sectors in order of forward rotation
    typedef enum logic [2:0] {
        RED     = 3'd0,
        YELLOW  = 3'd1,
        GREEN   = 3'd2,
        CYAN    = 3'd3,
        BLUE    = 3'd4,
        MAGENTA = 3'd5
    } sector_t;

    // Source of a channel duty within a sector: constant off, constant full,
    // ramping up with the level, or ramping down (MAX - level).
    typedef enum logic [1:0] {
        DS_OFF,
        DS_FULL,
        DS_UP,
        DS_DOWN
    } duty_src_t;

    typedef struct packed {
        duty_src_t r;
        duty_src_t g;
        duty_src_t b;
    } duty_sel_t;

    // Hue-to-duty mapping; kept width-free so the caller expands the
    // selection against its own PWM resolution.
    function automatic duty_sel_t hue_to_duty(input sector_t s);
        duty_sel_t d;
        case (s)
            RED:     d = '{DS_FULL, DS_UP,   DS_OFF };
            YELLOW:  d = '{DS_DOWN, DS_FULL, DS_OFF };
            GREEN:   d = '{DS_OFF,  DS_FULL, DS_UP  };
            CYAN:    d = '{DS_OFF,  DS_DOWN, DS_FULL};
            BLUE:    d = '{DS_UP,   DS_OFF,  DS_FULL};
            MAGENTA: d = '{DS_FULL, DS_OFF,  DS_DOWN};
            default: d = '{DS_FULL, DS_OFF,  DS_OFF };
        endcase
        return d;
    endfunction

endpackage

// File: rtl/pwm_cmp.sv
// One PWM channel: duty register loaded at the end of each PWM period,
// compare against the shared counter, registered active-low LED drive.
module pwm_cmp #(
    parameter int           W        = 8,
    parameter logic [W-1:0] RST_DUTY = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] cnt_i,
    input  logic         load_i,
    input  logic [W-1:0] duty_i,
    output logic         led_n_o
);

    logic [W-1:0] duty_q;
    logic         led_n_q;

    // Duty only changes at the period boundary so a period is never split
    always_ff @(posedge clk) begin
        if (rst)         duty_q <= RST_DUTY;
        else if (load_i) duty_q <= duty_i;
    end

    // Registered compare; LED is on (low) while the count is below the duty
    always_ff @(posedge clk) begin
        if (rst) led_n_q <= 1'b1;
        else     led_n_q <= !(cnt_i < duty_q);
    end

    assign led_n_o = led_n_q;

endmodule

// File: rtl/rgb_hue_fader.sv
// RGB hue fader: rotates hue through six sectors with a linear level ramp
// and drives three active-low PWM LED outputs.
// Optional macro RGB_REVERSE_EN adds the rev input for reverse rotation.
module rgb_hue_fader
    import rgb_pkg::*;
#(
    parameter int CLK_FREQ = 12_000_000,
    parameter int CYCLE_MS = 1000,
    parameter int PWM_BITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
`ifdef RGB_REVERSE_EN
    input  logic       rev,
`endif
    output logic       RGB_R,
    output logic       RGB_G,
    output logic       RGB_B,
    output logic [2:0] sector,
    output logic       cycle_done
);

    localparam int STEP_RAW    = CLK_FREQ / 1000 * CYCLE_MS / (6 * 2**PWM_BITS);
    localparam int STEP_CYCLES = (STEP_RAW < 1) ? 1 : STEP_RAW;
    localparam int SW          = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] LVL_MAX   = '1;
    localparam logic [PWM_BITS-1:0] PWM_LAST  = LVL_MAX - 1'b1;

    logic [SW-1:0]       step_q;
    logic [PWM_BITS-1:0] pwm_q;
    logic [PWM_BITS-1:0] level_q, level_d;
    sector_t             sector_q, sector_d;
    logic                cycle_done_q, cycle_done_d;
    logic                step_last, tick, pwm_last, rev_w;

`ifdef RGB_REVERSE_EN
    assign rev_w = rev;
`else
    assign rev_w = 1'b0;
`endif

    assign step_last = (step_q == STEP_LAST);
    assign tick      = en && step_last;
    assign pwm_last  = (pwm_q == PWM_LAST);

    // Step prescaler: runs only while enabled, holds otherwise
    always_ff @(posedge clk) begin
        if (rst)     step_q <= '0;
        else if (en) step_q <= step_last ? '0 : step_q + 1'b1;
    end

    // Free-running PWM counter, period of MAX clocks
    always_ff @(posedge clk) begin
        if (rst) pwm_q <= '0;
        else     pwm_q <= pwm_last ? '0 : pwm_q + 1'b1;
    end

    // Hue next state: level ramps, sector steps on level wrap
    always_comb begin
        level_d      = level_q;
        sector_d     = sector_q;
        cycle_done_d = 1'b0;
        if (tick) begin
            if (rev_w) begin
                if (level_q == '0) begin
                    level_d = LVL_MAX;
                    if (sector_q == RED) begin
                        sector_d     = MAGENTA;
                        cycle_done_d = 1'b1;
                    end else begin
                        sector_d = sector_t'(sector_q - 3'd1);
                    end
                end else begin
                    level_d = level_q - 1'b1;
                end
            end else begin
                if (level_q == LVL_MAX) begin
                    level_d = '0;
                    if (sector_q == MAGENTA) begin
                        sector_d     = RED;
                        cycle_done_d = 1'b1;
                    end else begin
                        sector_d = sector_t'(sector_q + 3'd1);
                    end
                end else begin
                    level_d = level_q + 1'b1;
                end
            end
        end
    end

    // Hue state and wrap pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q      <= '0;
            sector_q     <= RED;
            cycle_done_q <= 1'b0;
        end else begin
            level_q      <= level_d;
            sector_q     <= sector_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    // Expand a duty selection into a value at this PWM resolution
    function automatic logic [PWM_BITS-1:0] src_val(input duty_src_t s,
                                                    input logic [PWM_BITS-1:0] l);
        logic [PWM_BITS-1:0] v;
        case (s)
            DS_OFF:  v = '0;
            DS_FULL: v = LVL_MAX;
            DS_UP:   v = l;
            default: v = ~l;   // MAX - l for an all-ones MAX
        endcase
        return v;
    endfunction

    duty_sel_t                     sel;
    logic [2:0][PWM_BITS-1:0]      duty;   // [2]=R, [1]=G, [0]=B
    logic [2:0]                    led_n;

    assign sel     = hue_to_duty(sector_q);
    assign duty[2] = src_val(sel.r, level_q);
    assign duty[1] = src_val(sel.g, level_q);
    assign duty[0] = src_val(sel.b, level_q);

    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        pwm_cmp #(
            .W        (PWM_BITS),
            .RST_DUTY ((ch == 2) ? LVL_MAX : '0)
        ) u_pwm (
            .clk     (clk),
            .rst     (rst),
            .cnt_i   (pwm_q),
            .load_i  (pwm_last),
            .duty_i  (duty[ch]),
            .led_n_o (led_n[ch])
        );
    end

    assign {RGB_R, RGB_G, RGB_B} = led_n;
    assign sector     = sector_q;
    assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_rgb_hue_fader.sv
// Self-checking bench for rgb_hue_fader (small config: MAX=3, one clock per
// step). Define RGB_REVERSE_EN to also exercise reverse rotation.
module tb_rgb_hue_fader;

    localparam int MAX  = 3;
    localparam int NL   = MAX + 1;     // levels per sector
    localparam int NH   = 6 * NL;      // hue positions per revolution
    localparam int STEP = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       RGB_R, RGB_G, RGB_B;
    logic [2:0] sector;
    logic       cycle_done;
`ifdef RGB_REVERSE_EN
    logic       rev = 1'b0;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    rgb_hue_fader #(.CLK_FREQ(24000), .CYCLE_MS(1), .PWM_BITS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
`ifdef RGB_REVERSE_EN
        .rev        (rev),
`endif
        .RGB_R      (RGB_R),
        .RGB_G      (RGB_G),
        .RGB_B      (RGB_B),
        .sector     (sector),
        .cycle_done (cycle_done)
    );

    always #5 clk = ~clk;

    // Reference model: hue as a single position 0..NH-1 around the wheel
    int m_h, m_pwm, m_step;
    int m_d[3];     // R,G,B duty
    bit m_led[3];   // R,G,B active-low outputs
    bit m_cd;

    function automatic void model_edge(input bit r, input bit e, input bit rv);
        int s, l;
        bit tk;
        if (r) begin
            m_h = 0; m_pwm = 0; m_step = 0; m_cd = 0;
            m_d = '{MAX, 0, 0};
            m_led = '{1, 1, 1};
        end else begin
            for (int c = 0; c < 3; c++) m_led[c] = !(m_pwm < m_d[c]);
            if (m_pwm == MAX - 1) begin
                s = m_h / NL;
                l = m_h % NL;
                case (s)
                    0: m_d = '{MAX,     l,       0};
                    1: m_d = '{MAX - l, MAX,     0};
                    2: m_d = '{0,       MAX,     l};
                    3: m_d = '{0,       MAX - l, MAX};
                    4: m_d = '{l,       0,       MAX};
                    default: m_d = '{MAX, 0,     MAX - l};
                endcase
            end
            m_pwm = (m_pwm + 1) % MAX;
            tk = e && (m_step == STEP - 1);
            if (e) m_step = (m_step + 1) % STEP;
            m_cd = 0;
            if (tk) begin
                if (rv) begin
                    m_cd = (m_h == 0);
                    m_h  = (m_h + NH - 1) % NH;
                end else begin
                    m_h  = (m_h + 1) % NH;
                    m_cd = (m_h == 0);
                end
            end
        end
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // One clock: advance model with the applied inputs, compare after the edge
    task automatic clk_step();
        bit rv;
        rv = 1'b0;
`ifdef RGB_REVERSE_EN
        rv = rev;
`endif
        @(posedge clk);
        model_edge(rst, en, rv);
        #1;
        chk("model_R",   int'(RGB_R),      int'(m_led[0]));
        chk("model_G",   int'(RGB_G),      int'(m_led[1]));
        chk("model_B",   int'(RGB_B),      int'(m_led[2]));
        chk("model_sec", int'(sector),     m_h / NL);
        chk("model_cd",  int'(cycle_done), int'(m_cd));
    endtask

    task automatic run(input bit e, input int n);
        en = e;
        for (int i = 0; i < n; i++) clk_step();
    endtask

    typedef struct {
        bit       rst;
        bit       en;
        int       sec;
        bit       cd;
        bit       chk_rgb;
        bit [2:0] rgb;     // {R,G,B}
    } vec_t;

    vec_t tbl[26];
    bit [2:0] early_rgb[7] = '{3'b011, 3'b011, 3'b011, 3'b001, 3'b001, 3'b011, 3'b001};

    initial begin
        int on_r, on_g, on_b;

        // Directed table: two reset clocks, then one forward revolution
        tbl[0] = '{1, 0, 0, 0, 1, 3'b111};
        tbl[1] = '{1, 0, 0, 0, 1, 3'b111};
        for (int k = 1; k <= 24; k++) begin
            tbl[k+1].rst     = 0;
            tbl[k+1].en      = 1;
            tbl[k+1].sec     = (k % 24) / 4;
            tbl[k+1].cd      = (k == 24);
            tbl[k+1].chk_rgb = (k <= 7);
            tbl[k+1].rgb     = (k <= 7) ? early_rgb[k-1] : 3'b000;
        end

        for (int i = 0; i < 26; i++) begin
            rst = tbl[i].rst;
            en  = tbl[i].en;
            clk_step();
            chk("tbl_sec", int'(sector),     tbl[i].sec);
            chk("tbl_cd",  int'(cycle_done), int'(tbl[i].cd));
            if (tbl[i].chk_rgb)
                chk("tbl_rgb", int'({RGB_R, RGB_G, RGB_B}), int'(tbl[i].rgb));
        end

        // Sector 2 level 1 frozen: B 1/3, G 3/3, R 0/3
        rst = 1; en = 0; clk_step();
        rst = 0;
        run(1, 9);
        run(0, 4);
        on_r = 0; on_g = 0; on_b = 0;
        for (int i = 0; i < 3; i++) begin
            clk_step();
            on_r += int'(!RGB_R); on_g += int'(!RGB_G); on_b += int'(!RGB_B);
        end
        chk("s2_sec",  int'(sector), 2);
        chk("s2_on_r", on_r, 0);
        chk("s2_on_g", on_g, 3);
        chk("s2_on_b", on_b, 1);

        // Mid-sector 3 hold for 50 clocks: hue frozen, PWM keeps running
        run(1, 4);
        run(0, 47);
        on_r = 0; on_g = 0; on_b = 0;
        for (int i = 0; i < 3; i++) begin
            clk_step();
            on_r += int'(!RGB_R); on_g += int'(!RGB_G); on_b += int'(!RGB_B);
        end
        chk("s3_sec",  int'(sector), 3);
        chk("s3_on_r", on_r, 0);
        chk("s3_on_g", on_g, 2);
        chk("s3_on_b", on_b, 3);

        // Reset mid-sector 4: all off next clock, then RED restart
        run(1, 4);
        chk("s4_sec", int'(sector), 4);
        rst = 1; clk_step();
        chk("rst_rgb", int'({RGB_R, RGB_G, RGB_B}), 3'b111);
        chk("rst_sec", int'(sector), 0);
        rst = 0; en = 0; clk_step();
        chk("rel_rgb", int'({RGB_R, RGB_G, RGB_B}), 3'b011);
        chk("rel_sec", int'(sector), 0);

`ifdef RGB_REVERSE_EN
        // Reverse from reset: 0 wraps to 5 with a pulse, then 5,5,5,4
        rev = 1; rst = 1; en = 0; clk_step();
        rst = 0; en = 1;
        for (int i = 0; i < 5; i++) begin
            clk_step();
            chk("rev_sec", int'(sector), (i < 4) ? 5 : 4);
            chk("rev_cd",  int'(cycle_done), (i == 0) ? 1 : 0);
        end
        rev = 0;
`endif

        // Randomized run against the model
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            en  = ($urandom_range(0, 3) != 0);
`ifdef RGB_REVERSE_EN
            if ($urandom_range(0, 15) == 0) rev = ~rev;
`endif
            clk_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
